// File: rtl/fetch_aligner.sv
// Fetch aligner: turns the word-aligned 32-bit fetch stream into individual
// 16-bit (compressed) or 32-bit instructions, each tagged with its PC.
// A 4-halfword buffer absorbs instructions that straddle fetch words, and a
// redirect (flush) restarts the stream at any halfword-aligned target.
module fetch_aligner #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        fetch_valid_i,
    output logic        fetch_ready_o,
    input  logic [31:0] fetch_data_i,
    input  logic        flush_i,
    input  logic [31:0] flush_pc_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    output logic        is_compressed_o
);

    // Halfword buffer; hw_q[0] is the oldest halfword (the head).
    logic [15:0] hw_q [4];
    logic [15:0] hw_d [4];
    logic [2:0]  count_q, count_d;
    logic [31:0] pc_q, pc_d;
    logic        skip_low_q, skip_low_d;

    logic        head_compressed;
    logic        pop_fire;
    logic        push_fire;
    logic [1:0]  pop_n;
    logic [1:0]  push_n;
    logic [15:0] push_hw [2];
    int          surv;

    // Bit 0 of a redirect target is meaningless for halfword-aligned PCs.
    logic        unused_flush_pc_bit;
    assign unused_flush_pc_bit = flush_pc_i[0];

    assign head_compressed = (hw_q[0][1:0] != 2'b11);

    // Handshake and output decode from registered buffer state only.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and a latch cannot be inferred.
        instr_o         = 32'h0;
        is_compressed_o = 1'b0;
        fetch_ready_o   = (count_q <= 3'd2);
        instr_valid_o   = ((count_q >= 3'd1) && head_compressed) || (count_q >= 3'd2);
        instr_pc_o      = pc_q;
        // Stale halfwords beyond count never reach instr_o: gated by valid.
        if (instr_valid_o) begin
            is_compressed_o = head_compressed;
            instr_o         = head_compressed ? {16'h0, hw_q[0]} : {hw_q[1], hw_q[0]};
        end
    end

    // Pop/push sizes and the halfwords a fetch word contributes.
    always_comb begin
        pop_fire   = instr_valid_o && instr_ready_i;
        push_fire  = fetch_valid_i && fetch_ready_o;
        pop_n      = pop_fire ? (head_compressed ? 2'd1 : 2'd2) : 2'd0;
        push_n     = push_fire ? (skip_low_q ? 2'd1 : 2'd2) : 2'd0;
        push_hw[0] = skip_low_q ? fetch_data_i[31:16] : fetch_data_i[15:0];
        push_hw[1] = fetch_data_i[31:16];
    end

    // Halfwords that survive this cycle's pop.
    assign surv = int'(count_q) - int'(pop_n);

    // Next buffer state: shift survivors to the head, append pushed halfwords.
    always_comb begin
        hw_d       = hw_q;
        count_d    = 3'(surv + int'(push_n));
        pc_d       = pc_q + {29'd0, pop_n, 1'b0};
        skip_low_d = push_fire ? 1'b0 : skip_low_q;
        for (int i = 0; i < 4; i++) begin
            if (i < surv) begin
                hw_d[i] = hw_q[2'(i + int'(pop_n))];
            end else if ((i - surv) < int'(push_n)) begin
                hw_d[i] = push_hw[1'(i - surv)];
            end
        end
        // Redirect wins over any push or pop in the same cycle.
        if (flush_i) begin
            count_d    = 3'd0;
            pc_d       = {flush_pc_i[31:1], 1'b0};
            skip_low_d = flush_pc_i[1];
            hw_d       = hw_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q    <= 3'd0;
            pc_q       <= {RESET_PC[31:1], 1'b0};
            skip_low_q <= RESET_PC[1];
            // NOTE: the small halfword buffer is cleared on reset so no stale
            // contents survive a mid-stream reset; larger RAMs would not be.
            for (int i = 0; i < 4; i++) begin
                hw_q[i] <= 16'h0;
            end
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values computed above.
            count_q    <= count_d;
            pc_q       <= pc_d;
            skip_low_q <= skip_low_d;
            hw_q       <= hw_d;
        end
    end

endmodule

// File: tb/tb_fetch_aligner.sv
// Self-checking bench for fetch_aligner: table-driven fetch scenarios with a
// scoreboard of expected instructions, plus hand-written stall, flush,
// streaming and reset sequences.
module tb_fetch_aligner;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        fetch_valid_i = 1'b0;
    logic        fetch_ready_o;
    logic [31:0] fetch_data_i = 32'h0;
    logic        flush_i = 1'b0;
    logic [31:0] flush_pc_i = 32'h0;
    logic        instr_valid_o;
    logic        instr_ready_i = 1'b0;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        is_compressed_o;

    fetch_aligner #(.RESET_PC(32'h0000_0000)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .fetch_valid_i   (fetch_valid_i),
        .fetch_ready_o   (fetch_ready_o),
        .fetch_data_i    (fetch_data_i),
        .flush_i         (flush_i),
        .flush_pc_i      (flush_pc_i),
        .instr_valid_o   (instr_valid_o),
        .instr_ready_i   (instr_ready_i),
        .instr_o         (instr_o),
        .instr_pc_o      (instr_pc_o),
        .is_compressed_o (is_compressed_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } exp_t;

    typedef struct {
        logic [31:0]       flush_pc;
        int                n_words;
        logic [1:0][31:0]  words;
        logic              valid_after_first;
        int                n_exp;
        logic [2:0][31:0]  exp_instr;
        logic [2:0][31:0]  exp_pc;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[4];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic expect_instr(input logic [31:0] instr, input logic [31:0] pc);
        exp_t e;
        e.instr = instr;
        e.pc    = pc;
        sb.push_back(e);
    endtask

    // Present a word and hold it until accepted; fetch_valid_i stays high.
    task automatic push_word(input logic [31:0] w);
        int n = 0;
        fetch_valid_i = 1'b1;
        fetch_data_i  = w;
        while (!fetch_ready_o && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) begin
            check("push_timeout", 32'(fetch_ready_o), 32'd1);
        end
        tick();
    endtask

    task automatic do_flush(input logic [31:0] pc);
        flush_i    = 1'b1;
        flush_pc_i = pc;
        tick();
        flush_i    = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((sb.size() != 0 || instr_valid_o) && n < 100) begin
            @(posedge clk_i);
            #2;
            n++;
        end
        check("drain_left", 32'(sb.size()), 32'd0);
    endtask

    // Scoreboard monitor: compare every consumed instruction with the queue.
    always @(negedge clk_i) begin
        if (!rst_i && !flush_i && instr_valid_o && instr_ready_i) begin
            if (sb.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_instr: got %h @%h expected none", instr_o, instr_pc_o);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("instr", instr_o, e.instr);
                check("pc", instr_pc_o, e.pc);
                check("compressed", 32'(is_compressed_o), 32'(e.instr[1:0] != 2'b11));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] w;

        // Scenario table: redirect target, fetch words, expected instructions.
        vecs[0].flush_pc = 32'h0000_0000; vecs[0].n_words = 1;
        vecs[0].words[0] = 32'h4505_4501; vecs[0].valid_after_first = 1'b1;
        vecs[0].n_exp = 2;
        vecs[0].exp_instr[0] = 32'h0000_4501; vecs[0].exp_pc[0] = 32'h0;
        vecs[0].exp_instr[1] = 32'h0000_4505; vecs[0].exp_pc[1] = 32'h2;

        vecs[1].flush_pc = 32'h0000_0000; vecs[1].n_words = 2;
        vecs[1].words[0] = 32'h0513_4501; vecs[1].words[1] = 32'h4505_0010;
        vecs[1].valid_after_first = 1'b1; vecs[1].n_exp = 3;
        vecs[1].exp_instr[0] = 32'h0000_4501; vecs[1].exp_pc[0] = 32'h0;
        vecs[1].exp_instr[1] = 32'h0010_0513; vecs[1].exp_pc[1] = 32'h2;
        vecs[1].exp_instr[2] = 32'h0000_4505; vecs[1].exp_pc[2] = 32'h6;

        vecs[2].flush_pc = 32'h0000_0102; vecs[2].n_words = 1;
        vecs[2].words[0] = 32'h4505_4501; vecs[2].valid_after_first = 1'b1;
        vecs[2].n_exp = 1;
        vecs[2].exp_instr[0] = 32'h0000_4505; vecs[2].exp_pc[0] = 32'h102;

        // Halfword-aligned target whose first instruction straddles words.
        vecs[3].flush_pc = 32'h0000_1002; vecs[3].n_words = 2;
        vecs[3].words[0] = 32'h0513_4501; vecs[3].words[1] = 32'h4505_0010;
        vecs[3].valid_after_first = 1'b0; vecs[3].n_exp = 2;
        vecs[3].exp_instr[0] = 32'h0010_0513; vecs[3].exp_pc[0] = 32'h1002;
        vecs[3].exp_instr[1] = 32'h0000_4505; vecs[3].exp_pc[1] = 32'h1006;

        // Reset state.
        tick();
        tick();
        rst_i = 1'b0;
        check("rst_valid", 32'(instr_valid_o), 32'd0);
        check("rst_instr", instr_o, 32'h0);
        check("rst_pc", instr_pc_o, 32'h0);
        check("rst_comp", 32'(is_compressed_o), 32'd0);
        check("rst_ready", 32'(fetch_ready_o), 32'd1);

        // Table-driven scenarios with downstream always ready.
        instr_ready_i = 1'b1;
        for (int v = 0; v < 4; v++) begin
            do_flush(vecs[v].flush_pc);
            for (int k = 0; k < vecs[v].n_exp; k++) begin
                expect_instr(vecs[v].exp_instr[k], vecs[v].exp_pc[k]);
            end
            for (int k = 0; k < vecs[v].n_words; k++) begin
                push_word(vecs[v].words[k]);
                if (k == 0) begin
                    check("valid_after_first", 32'(instr_valid_o), 32'(vecs[v].valid_after_first));
                end
            end
            fetch_valid_i = 1'b0;
            wait_drain();
            check("idle_valid", 32'(instr_valid_o), 32'd0);
            check("idle_ready", 32'(fetch_ready_o), 32'd1);
        end

        // Backpressure: buffer fills, stalled inputs change nothing, drain in order.
        instr_ready_i = 1'b0;
        do_flush(32'h0);
        expect_instr(32'h0010_0513, 32'h0);
        expect_instr(32'h0020_0593, 32'h4);
        expect_instr(32'h0030_0613, 32'h8);
        push_word(32'h0010_0513);
        push_word(32'h0020_0593);
        fetch_valid_i = 1'b0;
        check("bp_ready_low", 32'(fetch_ready_o), 32'd0);
        check("bp_valid", 32'(instr_valid_o), 32'd1);
        fetch_valid_i = 1'b1;
        fetch_data_i  = 32'h0030_0613;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("bp_hold_ready", 32'(fetch_ready_o), 32'd0);
            check("bp_hold_instr", instr_o, 32'h0010_0513);
            check("bp_hold_pc", instr_pc_o, 32'h0);
        end
        instr_ready_i = 1'b1;
        push_word(32'h0030_0613);
        fetch_valid_i = 1'b0;
        wait_drain();

        // Flush in the same cycle as a fetch word and a ready consumer.
        instr_ready_i = 1'b0;
        push_word(32'h4505_4501);
        fetch_valid_i = 1'b0;
        check("pre_flush_valid", 32'(instr_valid_o), 32'd1);
        flush_i       = 1'b1;
        flush_pc_i    = 32'h0000_0200;
        fetch_valid_i = 1'b1;
        fetch_data_i  = 32'h0010_0513;
        instr_ready_i = 1'b1;
        tick();
        flush_i       = 1'b0;
        fetch_valid_i = 1'b0;
        check("flush_valid", 32'(instr_valid_o), 32'd0);
        check("flush_pc", instr_pc_o, 32'h0000_0200);
        check("flush_ready", 32'(fetch_ready_o), 32'd1);
        tick();
        check("flush_word_dropped", 32'(instr_valid_o), 32'd0);

        // Back-to-back 32-bit stream across the PC wrap.
        do_flush(32'hFFFF_FFF4);
        w = 32'hFFFF_FFF4;
        for (int k = 0; k < 5; k++) begin
            expect_instr(32'h0010_0513, w);
            w = w + 32'd4;
        end
        for (int k = 0; k < 5; k++) begin
            check("stream_ready", 32'(fetch_ready_o), 32'd1);
            push_word(32'h0010_0513);
            check("stream_valid", 32'(instr_valid_o), 32'd1);
        end
        fetch_valid_i = 1'b0;
        wait_drain();
        check("wrap_pc", instr_pc_o, 32'h0000_0008);

        // Reset asserted with a buffered instruction.
        instr_ready_i = 1'b0;
        push_word(32'h0010_0513);
        fetch_valid_i = 1'b0;
        check("pre_rst_valid", 32'(instr_valid_o), 32'd1);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check("midrst_valid", 32'(instr_valid_o), 32'd0);
        check("midrst_pc", instr_pc_o, 32'h0);
        check("midrst_instr", instr_o, 32'h0);
        check("midrst_ready", 32'(fetch_ready_o), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fetch_aligner.md
Name: fetch_aligner

Overview:
- Realigns the word-aligned 32-bit instruction fetch stream into individual instructions, 16-bit or 32-bit, each with its PC.
- Sits between the instruction fetch interface and the compressed-instruction expander/decoder stage.
- Handles 32-bit instructions that straddle word boundaries, and redirects (flushes) to halfword-aligned targets.
- Fully synchronous; one output instruction per cycle maximum.

Parameters:
RESET_PC, 32'h0000_0000, PC of first instruction after reset (bit 0 ignored)

Ports:
clk_i  input  1  clock
rst_i  input  1  synchronous reset, active-high
fetch_valid_i  input  1  fetch word valid
fetch_ready_o  output  1  aligner can accept a fetch word this cycle
fetch_data_i  input  32  word-aligned fetch data, little-endian halfwords ([15:0] = lower address)
flush_i  input  1  redirect; discards all buffered state
flush_pc_i  input  32  redirect target PC (bit 0 ignored)
instr_valid_o  output  1  instr_o/instr_pc_o hold a complete instruction
instr_ready_i  input  1  downstream consumes instruction
instr_o  output  32  instruction; [31:16]=16'h0 when compressed
instr_pc_o  output  32  PC of instr_o, bit 0 always 0
is_compressed_o  output  1  instr_o[1:0] != 2'b11

Behaviour:
- Storage: 4-halfword buffer hw[0..3] (hw[0] = head), count 0..4, head PC register pc_q, skip_low flag.
- Reset: count=0, pc_q={RESET_PC[31:1],1'b0}, skip_low=RESET_PC[1], instr_valid_o=0, instr_o=0, instr_pc_o=pc_q, is_compressed_o=0.
- fetch_ready_o = (count <= 2). It is a function of registered state only; there is no combinational path from instr_ready_i.
- Push (fetch_valid_i && fetch_ready_o):
  - skip_low=1: append fetch_data_i[31:16] only (+1 halfword), then clear skip_low.
  - skip_low=0: append [15:0] then [31:16] (+2 halfwords).
- Output valid:
  - instr_valid_o = (count>=1 && hw[0][1:0]!=2'b11) || (count>=2). Computed combinationally from buffer state.
  - Compressed: instr_o={16'h0,hw[0]}.
  - Uncompressed: instr_o={hw[1],hw[0]}.
  - instr_pc_o=pc_q.
- Pop (instr_valid_o && instr_ready_i): remove 1 halfword (compressed) or 2 halfwords (uncompressed), shift the remaining halfwords to the head, and advance pc_q by 2 or 4 (mod 2^32 wrap).
- Simultaneous push and pop in one cycle: new count = count - popped + pushed. Pushed halfwords land directly after the surviving ones.
- Latency: a word accepted in cycle N can produce instr_valid_o in cycle N+1.
- Throughput:
  - Sustained 1 instr/cycle for all-32-bit streams: count holds at 2, pop 2 + push 2 each cycle.
  - All-compressed streams also run at 1 instr/cycle.
- Flush has priority over push and pop in the same cycle:
  - count=0, pc_q={flush_pc_i[31:1],1'b0}, skip_low=flush_pc_i[1].
  - A word presented in the flush cycle is not accepted. fetch_ready_o is still driven from pre-flush count, but the push is dropped regardless of handshake.
  - No pop is counted in the flush cycle.
- Reset asserted mid-stream is identical to flush to RESET_PC, and additionally clears all buffer contents.
- Uncompressed head with count==1 (straddle): instr_valid_o=0 until the next word arrives. No timeout.
- Buffer contents beyond count are don't-care, but must never reach instr_o while instr_valid_o=1.
- No illegal-instruction checks here; those are decoded downstream.

Test Plan:
- Reset, then push 0x4505_4501 → cycle+1: instr_o=0x0000_4501 pc=0 compressed; next: 0x0000_4505 pc=2; then valid=0, count=0.
- Straddle: push 0x0513_4501, then 0x4505_0010 → outputs 0x0000_4501 @0, 0x0010_0513 @2 (uncompressed), 0x0000_4505 @6.
- Flush to 0x0000_0102, then push 0x4505_4501 → single output 0x0000_4505 @0x102. The low half is dropped.
- Backpressure:
  - Hold instr_ready_i=0 while pushing 3 words of 32-bit instructions → fetch_ready_o drops to 0 after count>2.
  - Holding the stalled inputs changes nothing.
  - Releasing instr_ready_i drains in order with pc 0,4,8.
- Flush in the same cycle as fetch_valid_i with instr_ready_i=1 → the word is not buffered, no pop counted, instr_valid_o=0 next cycle, pc_q=target.
- Streaming 32-bit instructions 0x0010_0513 back-to-back with instr_ready_i=1 → instr_valid_o stays high every cycle after the first, pc steps by 4. Include a wrap from 0xFFFF_FFFC to 0x0000_0000.
